// File: rtl/keypad_entry_encoder_pkg.sv
// Shared key-pad definitions: key FSM states, debounce default, BCD width and encode helpers.
// Combinational helpers only; no timing or flow control of their own.
package keypad_entry_encoder_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 3;
  localparam int BCD_W               = 4;
  localparam int NUM_KEYS            = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } key_state_t;

  function automatic logic is_onehot(input logic [NUM_KEYS-1:0] p);
    return (p != '0) && ((p & (p - NUM_KEYS'(1))) == '0);
  endfunction

  function automatic logic [BCD_W-1:0] key_to_bcd(input logic [NUM_KEYS-1:0] p);
    logic [BCD_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (p[i]) idx = BCD_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Active-low button: 2-flop sync + debounce, one-cycle pulse on accepted press; 2+DEBOUNCE_CYCLES clocks.
// No backpressure: the pulse is a single-cycle strobe, a release produces nothing.
module button_debouncer
  import keypad_entry_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 3
) (
  input  logic clock,
  input  logic resetn,
  input  logic btn_n_raw,
  output logic pulse
);

  localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync1;
  logic             bs;
  logic             level;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt + CNT_W'(1);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b1;
      bs    <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync1 <= btn_n_raw;
      bs    <= sync1;
      pulse <= 1'b0;
      if (bs != level) begin
        if (cnt_inc == DEB_LIM) begin
          level <= bs;
          cnt   <= '0;
          // level is still 1 here only on a press (1->0 flip)
          pulse <= level;
        end else begin
          cnt <= cnt_inc;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/keypad_entry_encoder.sv
// Sync/debounce the 10-key pad and three buttons into one-cycle digit, error and command strobes.
// Latency 2+DEBOUNCE_CYCLES clocks from raw sample; no backpressure, held keys never repeat.
module keypad_entry_encoder
  import keypad_entry_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 3
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic                startn_raw,
  input  logic                stopn_raw,
  input  logic                clearn_raw,
  output logic [BCD_W-1:0]    digit,
  output logic                digit_valid,
  output logic                key_error,
  output logic                start_pulse,
  output logic                stop_pulse,
  output logic                clear_pulse
);

  localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEBOUNCE_CYCLES);

  logic [NUM_KEYS-1:0] ks_meta;
  logic [NUM_KEYS-1:0] ks;
  logic [NUM_KEYS-1:0] pat, pat_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt, cnt_inc;
  logic [BCD_W-1:0]    digit_nxt;
  logic                valid_nxt;
  logic                err_nxt;
  key_state_t          state, state_nxt;

  assign cnt_inc = cnt + CNT_W'(1);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ks_meta     <= '0;
      ks          <= '0;
      state       <= ST_IDLE;
      cnt         <= '0;
      pat         <= '0;
      digit       <= '0;
      digit_valid <= 1'b0;
      key_error   <= 1'b0;
    end else begin
      ks_meta     <= keys;
      ks          <= ks_meta;
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pat         <= pat_nxt;
      digit       <= digit_nxt;
      digit_valid <= valid_nxt;
      key_error   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pat_nxt   = pat;
    digit_nxt = digit;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ks != '0) begin
          pat_nxt   = ks;
          cnt_nxt   = CNT_W'(1);
          state_nxt = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (ks == '0) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end else if (ks != pat) begin
          // pattern moved: restart the stability window on the new pattern
          pat_nxt = ks;
          cnt_nxt = CNT_W'(1);
        end else if (cnt_inc == DEB_LIM) begin
          cnt_nxt   = cnt_inc;
          state_nxt = ST_HELD;
          if (is_onehot(pat)) begin
            digit_nxt = key_to_bcd(pat);
            valid_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ST_HELD: begin
        if (ks == '0) begin
          cnt_nxt   = CNT_W'(1);
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (ks != '0) begin
          state_nxt = ST_HELD;
        end else if (cnt_inc == DEB_LIM) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_start (
    .clock(clock), .resetn(resetn), .btn_n_raw(startn_raw), .pulse(start_pulse)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_stop (
    .clock(clock), .resetn(resetn), .btn_n_raw(stopn_raw), .pulse(stop_pulse)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_clear (
    .clock(clock), .resetn(resetn), .btn_n_raw(clearn_raw), .pulse(clear_pulse)
  );

endmodule

// File: tb/tb_keypad_entry_encoder.sv
// Directed stimulus for keypad_entry_encoder; expected strobes (kind, digit, cycle) are queued
// by the stimulus and matched by a forked monitor whenever any strobe is seen.
module tb_keypad_entry_encoder;

  localparam int K_DIGIT = 0;
  localparam int K_ERR   = 1;
  localparam int K_START = 2;
  localparam int K_STOP  = 3;
  localparam int K_CLEAR = 4;
  // raw edge E -> strobe sampled on the negedge after edge E+4
  localparam int LAT     = 5;

  typedef struct {
    int kind;
    int dig;
    int cyc;
  } exp_t;

  logic       clock;
  logic       resetn;
  logic [9:0] keys;
  logic       startn_raw, stopn_raw, clearn_raw;
  logic [3:0] digit;
  logic       digit_valid, key_error, start_pulse, stop_pulse, clear_pulse;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  keypad_entry_encoder dut (
    .clock(clock), .resetn(resetn), .keys(keys),
    .startn_raw(startn_raw), .stopn_raw(stopn_raw), .clearn_raw(clearn_raw),
    .digit(digit), .digit_valid(digit_valid), .key_error(key_error),
    .start_pulse(start_pulse), .stop_pulse(stop_pulse), .clear_pulse(clear_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic expect_evt(input int kind, input int dig, input int at);
    exp_t e;
    e.kind = kind;
    e.dig  = dig;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  task automatic observe(input int kind, input int dig);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_strobe: got kind %0d digit %0d at cycle %0d, expected no strobe",
               kind, dig, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.dig != dig || e.cyc != cyc) begin
        errors++;
        $display("FAIL strobe: got kind %0d digit %0d cycle %0d, expected kind %0d digit %0d cycle %0d",
                 kind, dig, cyc, e.kind, e.dig, e.cyc);
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clock);
      if (resetn) begin
        if (digit_valid) observe(K_DIGIT, int'(digit));
        if (key_error)   observe(K_ERR,   int'(digit));
        if (start_pulse) observe(K_START, 0);
        if (stop_pulse)  observe(K_STOP,  0);
        if (clear_pulse) observe(K_CLEAR, 0);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_digit"},       int'(digit),       0);
    chk({tag, "_digit_valid"}, int'(digit_valid), 0);
    chk({tag, "_key_error"},   int'(key_error),   0);
    chk({tag, "_start"},       int'(start_pulse), 0);
    chk({tag, "_stop"},        int'(stop_pulse),  0);
    chk({tag, "_clear"},       int'(clear_pulse), 0);
  endtask

  // exp_kind < 0 means the press must produce no strobe
  task automatic key_press(input logic [9:0] v, input int hold, input int exp_kind, input int exp_dig);
    keys = v;
    if (exp_kind >= 0) expect_evt(exp_kind, exp_dig, cyc + LAT);
    step(hold);
    keys = '0;
    step(12);
  endtask

  // mask bits: {start, stop, clear}
  task automatic btn_press(input logic [2:0] mask, input int hold, input logic want);
    startn_raw = ~mask[2];
    stopn_raw  = ~mask[1];
    clearn_raw = ~mask[0];
    if (want) begin
      if (mask[2]) expect_evt(K_START, 0, cyc + LAT);
      if (mask[1]) expect_evt(K_STOP,  0, cyc + LAT);
      if (mask[0]) expect_evt(K_CLEAR, 0, cyc + LAT);
    end
    step(hold);
    startn_raw = 1'b1;
    stopn_raw  = 1'b1;
    clearn_raw = 1'b1;
    step(12);
  endtask

  initial begin
    resetn     = 1'b0;
    keys       = '0;
    startn_raw = 1'b1;
    stopn_raw  = 1'b1;
    clearn_raw = 1'b1;
    fork
      monitor();
    join_none
    step(3);
    check_quiet("reset");
    resetn = 1'b1;
    step(2);

    key_press(10'b0000000010, 5, K_DIGIT, 1);
    key_press(10'b0100000000, 5, K_DIGIT, 8);
    key_press(10'b0000000100, 200, K_DIGIT, 2);
    key_press(10'b0000000100, 2, -1, 0);

    // 2 high, 1-clock gap, then stable: only the post-gap run counts
    keys = 10'b0000100000;
    step(2);
    keys = '0;
    step(1);
    keys = 10'b0000100000;
    expect_evt(K_DIGIT, 5, cyc + LAT);
    step(5);
    keys = '0;
    step(12);

    key_press(10'b0000000110, 5, K_ERR, 5);

    btn_press(3'b100, 5, 1'b1);
    btn_press(3'b011, 5, 1'b1);
    btn_press(3'b100, 1, 1'b0);

    // reset while key 3 is still debouncing, key kept down across reset
    keys = 10'b0000001000;
    step(3);
    #2 resetn = 1'b0;
    #1 check_quiet("async_reset");
    @(negedge clock);
    resetn = 1'b1;
    expect_evt(K_DIGIT, 3, cyc + LAT);
    step(8);
    keys = '0;
    step(12);

    chk("strobes_outstanding", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
